// File: rtl/cory_arb2.sv
// cory_arb2: two-input round-robin arbiter feeding one registered valid/ready output stage.
// Define CORY_ARB2_LOCK_EN to hold the grant from the first to the last beat of a packet.
module cory_arb2 #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a0_v,
    input  logic [N-1:0] i_a0_d,
    input  logic         i_a0_l,
    output logic         o_a0_r,
    input  logic         i_a1_v,
    input  logic [N-1:0] i_a1_d,
    input  logic         i_a1_l,
    output logic         o_a1_r,
    output logic         o_z_v,
    output logic [N-1:0] o_z_d,
    output logic         o_z_l,
    output logic         o_z_s,
    input  logic         i_z_r
);

    logic         load;
    logic         gnt_any;
    logic         gnt;
    logic         gnt_valid;
    logic         acc;
    logic [N-1:0] acc_d;
    logic         acc_l;
    logic         ptr;

`ifdef CORY_ARB2_LOCK_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } lock_t;

    lock_t state;
`endif

    assign load = !o_z_v || i_z_r;

    // A lock pins the grant to its owner even while the owner is not valid.
    always_comb begin
        gnt_any = i_a0_v || i_a1_v;
        gnt     = (i_a0_v && i_a1_v) ? ptr : i_a1_v;
`ifdef CORY_ARB2_LOCK_EN
        if (state != IDLE) begin
            gnt_any = 1'b1;
            gnt     = (state == LOCK1);
        end
`endif
    end

    assign gnt_valid = gnt ? i_a1_v : i_a0_v;
    assign acc       = load && gnt_any && gnt_valid;
    assign acc_d     = gnt ? i_a1_d : i_a0_d;
    assign acc_l     = gnt ? i_a1_l : i_a0_l;
    assign o_a0_r    = load && gnt_any && !gnt;
    assign o_a1_r    = load && gnt_any && gnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_z_v <= 1'b0;
            o_z_d <= '0;
            o_z_l <= 1'b0;
            o_z_s <= 1'b0;
            ptr   <= 1'b0;
`ifdef CORY_ARB2_LOCK_EN
            state <= IDLE;
`endif
        end else begin
            if (load) begin
                o_z_v <= acc;
                if (acc) begin
                    o_z_d <= acc_d;
                    o_z_l <= acc_l;
                    o_z_s <= gnt;
                end
            end
            if (acc) begin
`ifdef CORY_ARB2_LOCK_EN
                case (state)
                    IDLE: begin
                        if (acc_l) begin
                            ptr <= ~gnt;
                        end else begin
                            state <= gnt ? LOCK1 : LOCK0;
                        end
                    end
                    default: begin
                        if (acc_l) begin
                            state <= IDLE;
                            ptr   <= ~gnt;
                        end
                    end
                endcase
`else
                ptr <= ~gnt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cory_arb2.sv
// tb_cory_arb2: directed scenarios plus randomized traffic checked against a cycle model
// of the arbitration rules and a per-source in-order scoreboard.
module tb_cory_arb2;

    localparam int N = 8;
`ifdef CORY_ARB2_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         a0V = 1'b0, a0L = 1'b0, a1V = 1'b0, a1L = 1'b0;
    logic [N-1:0] a0D = '0, a1D = '0;
    logic         a0R, a1R;
    logic         zV, zL, zS;
    logic [N-1:0] zD;
    logic         zReady = 1'b0;

    int errorCount = 0;
    int checkCount = 0;

    // Source side: pending beats per requester plus the beat currently presented.
    logic [7:0] pendD [2][1024];
    bit         pendL [2][1024];
    int         pHead [2];
    int         pTail [2];
    bit         srcV  [2];
    logic [7:0] srcD  [2];
    bit         srcL  [2];
    bit         srcEn [2];
    bit         randGaps;

    // Scoreboard of beats accepted per source, in order.
    logic [7:0] sentD [2][1024];
    bit         sentL [2][1024];
    int         sHead [2];
    int         sTail [2];

    // Reference model of the arbiter's visible state.
    bit         mV;
    logic [7:0] mD;
    bit         mL;
    int         mS;
    int         mPtr;
    int         mLock;

    // Observed downstream transfers for directed tests.
    int outS [64];
    int outD [64];
    int outCyc [64];
    int outN;
    int cycNum;

    cory_arb2 #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_a0_v  (a0V),
        .i_a0_d  (a0D),
        .i_a0_l  (a0L),
        .o_a0_r  (a0R),
        .i_a1_v  (a1V),
        .i_a1_d  (a1D),
        .i_a1_l  (a1L),
        .o_a1_r  (a1R),
        .o_z_v   (zV),
        .o_z_d   (zD),
        .o_z_l   (zL),
        .o_z_s   (zS),
        .i_z_r   (zReady)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void pushBeat(input int i, input logic [7:0] d, input bit l);
        pendD[i][pTail[i] % 1024] = d;
        pendL[i][pTail[i] % 1024] = l;
        pTail[i]++;
    endfunction

    function automatic void clearAll();
        for (int i = 0; i < 2; i++) begin
            pHead[i] = 0;
            pTail[i] = 0;
            sHead[i] = 0;
            sTail[i] = 0;
            srcV[i]  = 1'b0;
            srcD[i]  = '0;
            srcL[i]  = 1'b0;
            srcEn[i] = 1'b1;
        end
        randGaps = 1'b0;
        mV = 1'b0; mD = '0; mL = 1'b0; mS = 0; mPtr = 0; mLock = -1;
        outN = 0;
        cycNum = 0;
    endfunction

    task automatic applyStimulus();
        for (int i = 0; i < 2; i++) begin
            if (!srcV[i] && (pTail[i] > pHead[i]) && srcEn[i] &&
                (!randGaps || $urandom_range(0, 3) != 0)) begin
                srcV[i] = 1'b1;
                srcD[i] = pendD[i][pHead[i] % 1024];
                srcL[i] = pendL[i][pHead[i] % 1024];
            end
        end
        a0V = srcV[0]; a0D = srcD[0]; a0L = srcL[0];
        a1V = srcV[1]; a1D = srcD[1]; a1L = srcL[1];
    endtask

    task automatic applyReset();
        #2;
        reset_n = 1'b0;
        clearAll();
        applyStimulus();
        #1;
        checkOutput("rstZv", 32'(zV), 32'd0);
        checkOutput("rstZd", 32'(zD), 32'd0);
        checkOutput("rstZl", 32'(zL), 32'd0);
        checkOutput("rstZs", 32'(zS), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock of stimulus, output checks at the falling edge, model update after the rising edge.
    task automatic cycle();
        bit anyG;
        int g;
        bit ld;
        bit acc;
        int s;
        applyStimulus();
        @(negedge clk);
        checkOutput("zV", 32'(zV), 32'(mV));
        if (mV) begin
            checkOutput("zD", 32'(zD), 32'(mD));
            checkOutput("zL", 32'(zL), 32'(mL));
            checkOutput("zS", 32'(zS), 32'(mS));
        end
        if (mLock >= 0) begin
            anyG = 1'b1; g = mLock;
        end else if (srcV[0] && srcV[1]) begin
            anyG = 1'b1; g = mPtr;
        end else if (srcV[0]) begin
            anyG = 1'b1; g = 0;
        end else if (srcV[1]) begin
            anyG = 1'b1; g = 1;
        end else begin
            anyG = 1'b0; g = 0;
        end
        ld = !mV || zReady;
        checkOutput("a0R", 32'(a0R), 32'(ld && anyG && g == 0));
        checkOutput("a1R", 32'(a1R), 32'(ld && anyG && g == 1));
        if (zV && zReady) begin
            s = int'(zS);
            checkOutput("sbPending", 32'(sTail[s] > sHead[s]), 32'd1);
            if (sTail[s] > sHead[s]) begin
                checkOutput("sbData", 32'(zD), 32'(sentD[s][sHead[s] % 1024]));
                checkOutput("sbLast", 32'(zL), 32'(sentL[s][sHead[s] % 1024]));
                sHead[s]++;
            end
            if (outN < 64) begin
                outS[outN] = s;
                outD[outN] = int'(zD);
                outCyc[outN] = cycNum;
                outN++;
            end
        end
        acc = ld && anyG && srcV[g];
        @(posedge clk);
        #1;
        if (ld) begin
            mV = acc;
            if (acc) begin
                mD = srcD[g]; mL = srcL[g]; mS = g;
            end
        end
        if (acc) begin
            if (LOCK_EN) begin
                if (mLock < 0) begin
                    if (srcL[g]) mPtr = 1 - g;
                    else mLock = g;
                end else if (srcL[g]) begin
                    mLock = -1;
                    mPtr = 1 - g;
                end
            end else begin
                mPtr = 1 - g;
            end
            sentD[g][sTail[g] % 1024] = srcD[g];
            sentL[g][sTail[g] % 1024] = srcL[g];
            sTail[g]++;
            pHead[g]++;
            srcV[g] = 1'b0;
        end
        cycNum++;
    endtask

    task automatic checkStream(input string tag, input int idx, input int s, input int d);
        checkOutput(tag, (idx < outN) ? 32'(outS[idx] * 256 + outD[idx]) : 32'hFFFF_FFFF,
                    32'(s * 256 + d));
    endtask

    int expS [4];
    int expD [4];
    int expCyc;
    bit idle;

    initial begin
        clearAll();
        applyReset();

        // Idle after reset: nothing valid, nothing ready.
        zReady = 1'b1;
        cycle();
        checkOutput("idleZv", 32'(zV), 32'd0);
        checkOutput("idleA0R", 32'(a0R), 32'd0);
        checkOutput("idleA1R", 32'(a1R), 32'd0);
        checkOutput("idleZs", 32'(zS), 32'd0);

        // Single-beat packets from both sides alternate at full rate.
        applyReset();
        for (int k = 0; k < 4; k++) begin
            pushBeat(0, 8'(8'h01 + k), 1'b1);
            pushBeat(1, 8'(8'h81 + k), 1'b1);
        end
        zReady = 1'b1;
        for (int k = 0; k < 11; k++) cycle();
        for (int k = 0; k < 8; k++)
            checkStream("altSeq", k, k % 2, (k % 2 == 0) ? (8'h01 + k / 2) : (8'h81 + k / 2));
        checkOutput("altFirstCyc", 32'(outCyc[0]), 32'd1);
        checkOutput("altLastCyc", 32'(outCyc[7]), 32'd8);

        // Three-beat packet on a0 against a single beat on a1.
        applyReset();
        pushBeat(0, 8'h11, 1'b0);
        pushBeat(0, 8'h12, 1'b0);
        pushBeat(0, 8'h13, 1'b1);
        pushBeat(1, 8'hA0, 1'b1);
`ifdef CORY_ARB2_LOCK_EN
        expS = '{0, 0, 0, 1};
        expD = '{8'h11, 8'h12, 8'h13, 8'hA0};
`else
        expS = '{0, 1, 0, 0};
        expD = '{8'h11, 8'hA0, 8'h12, 8'h13};
`endif
        for (int k = 0; k < 8; k++) cycle();
        for (int k = 0; k < 4; k++) checkStream("pktSeq", k, expS[k], expD[k]);

        // Backpressure: output frozen for four cycles, then everything drains once.
        applyReset();
        for (int k = 0; k < 3; k++) begin
            pushBeat(0, 8'(8'h31 + k), 1'b1);
            pushBeat(1, 8'(8'hC1 + k), 1'b1);
        end
        zReady = 1'b1;
        cycle();
        cycle();
        zReady = 1'b0;
        expCyc = int'(mD);
        for (int k = 0; k < 4; k++) begin
            cycle();
            checkOutput("bpHoldD", 32'(zD), 32'(expCyc));
        end
        zReady = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        checkOutput("bpCount", 32'(outN), 32'd6);
        for (int k = 0; k < 6; k++)
            checkStream("bpSeq", k, k % 2, (k % 2 == 0) ? (8'h31 + k / 2) : (8'hC1 + k / 2));

        // a0 stalls mid-packet while a1 waits.
        applyReset();
        pushBeat(0, 8'h21, 1'b0);
        pushBeat(0, 8'h22, 1'b1);
        pushBeat(1, 8'hB0, 1'b1);
        cycle();
        srcEn[0] = 1'b0;
        cycle();
        cycle();
        srcEn[0] = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
`ifdef CORY_ARB2_LOCK_EN
        expS[0:2] = '{0, 0, 1};
        expD[0:2] = '{8'h21, 8'h22, 8'hB0};
        expCyc = 4;
`else
        expS[0:2] = '{0, 1, 0};
        expD[0:2] = '{8'h21, 8'hB0, 8'h22};
        expCyc = 2;
`endif
        for (int k = 0; k < 3; k++) checkStream("stallSeq", k, expS[k], expD[k]);
        checkOutput("stallCyc", 32'(outCyc[1]), 32'(expCyc));

        // Reset in the middle of an a1 packet, then both request.
        applyReset();
        pushBeat(1, 8'h51, 1'b0);
        pushBeat(1, 8'h52, 1'b0);
        pushBeat(1, 8'h53, 1'b1);
        cycle();
        cycle();
        applyReset();
        pushBeat(0, 8'h61, 1'b1);
        pushBeat(1, 8'h71, 1'b1);
        for (int k = 0; k < 4; k++) cycle();
        checkStream("rstSeq0", 0, 0, 8'h61);
        checkStream("rstSeq1", 1, 1, 8'h71);
        checkOutput("rstFirstCyc", 32'(outCyc[0]), 32'd1);

        // Randomized traffic with gaps and backpressure.
        applyReset();
        randGaps = 1'b1;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (pTail[i] - pHead[i] < 4) begin
                    automatic int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        pushBeat(i, 8'($urandom_range(0, 255)), b == len - 1);
                end
            end
            zReady = ($urandom_range(0, 3) != 0);
            cycle();
        end
        randGaps = 1'b0;
        zReady = 1'b1;
        idle = 1'b0;
        for (int k = 0; k < 200 && !idle; k++) begin
            cycle();
            idle = (pTail[0] == pHead[0]) && (pTail[1] == pHead[1]) &&
                   !srcV[0] && !srcV[1] && !mV;
        end
        checkOutput("drainDone", 32'(idle), 32'd1);
        checkOutput("sbEmpty", 32'((sTail[0] - sHead[0]) + (sTail[1] - sHead[1])), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
